cpu_clk_ctrl: RTL and testbench

Parametrised CPU clock-enable controller that replaces the fixed slow-clock wrapper around `cpu_dec`. The core stays on the board clock, and this block issues single-cycle `CPU_EN` pulses. Pulse rate follows one of four modes: halt, divided run, full-speed run, or single-step from a debounced push button. It also counts issued pulses so the count can be shown on the HEX displays.

---
 rtl/cpu_clk_pkg.sv | 25 ++
 rtl/key_debounce.sv | 58 +++++
 rtl/cpu_clk_ctrl.sv | 98 +++++++++
 tb/tb_cpu_clk_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_clk_pkg.sv
// Shared mode encodings and controller state type for the CPU clock-enable block.
package cpu_clk_pkg;

   localparam logic [1:0] MODE_HALT = 2'b00;
   localparam logic [1:0] MODE_RUN  = 2'b01;
   localparam logic [1:0] MODE_STEP = 2'b10;
   localparam logic [1:0] MODE_FAST = 2'b11;

   typedef enum logic [1:0] {
      ST_HALT = MODE_HALT,
      ST_RUN  = MODE_RUN,
      ST_STEP = MODE_STEP,
      ST_FAST = MODE_FAST
   } clk_state_t;

   function automatic clk_state_t decode_mode(input logic [1:0] mode);
      case (mode)
         MODE_RUN:  decode_mode = ST_RUN;
         MODE_STEP: decode_mode = ST_STEP;
         MODE_FAST: decode_mode = ST_FAST;
         default:   decode_mode = ST_HALT;
      endcase
   endfunction

endpackage

// File: rtl/key_debounce.sv
// Synchronises an active-low push button, debounces it and emits a one-cycle
// pulse when the accepted level falls (press); releases are silent.
module key_debounce #(
   parameter int SYNC_STAGES = 2,
   parameter int DEBOUNCE_W  = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_n,
   output logic press
);

   localparam logic [DEBOUNCE_W-1:0] CNT_ZERO = {DEBOUNCE_W{1'b0}};
   localparam logic [DEBOUNCE_W-1:0] CNT_ONE  = {{(DEBOUNCE_W-1){1'b0}}, 1'b1};

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [DEBOUNCE_W-1:0]  cnt_q, cnt_d;
   logic                   level_q, level_d;
   logic                   press_q, press_d;
   logic                   key_s;

   assign key_s = sync_q[SYNC_STAGES-1];

   // Any sample agreeing with the accepted level restarts the stability count.
   always_comb begin
      sync_d  = {sync_q[SYNC_STAGES-2:0], key_n};
      cnt_d   = cnt_q;
      level_d = level_q;
      press_d = 1'b0;
      if (key_s == level_q) begin
         cnt_d = CNT_ZERO;
      end else if (&cnt_q) begin
         level_d = key_s;
         cnt_d   = CNT_ZERO;
         press_d = ~key_s;
      end else begin
         cnt_d = cnt_q + CNT_ONE;
      end
   end

   // Key state registers; released level on reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q  <= {SYNC_STAGES{1'b1}};
         cnt_q   <= CNT_ZERO;
         level_q <= 1'b1;
         press_q <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         press_q <= press_d;
      end
   end

   assign press = press_q;

endmodule

// File: rtl/cpu_clk_ctrl.sv
// CPU clock-enable controller: issues single-cycle CPU_EN pulses in halt,
// divided-run, full-speed or single-step mode, and counts the pulses issued.
module cpu_clk_ctrl
   import cpu_clk_pkg::*;
#(
   parameter int DIV_W       = 26,
   parameter int DEBOUNCE_W  = 16,
   parameter int SYNC_STAGES = 2,
   parameter int TICK_W      = 16
) (
   input  logic              CLK,
   input  logic              RESET_N,
   input  logic [1:0]        MODE,
   input  logic [DIV_W-1:0]  DIV_N,
   input  logic              STEP_KEY_N,
   output logic              CPU_EN,
   output logic [TICK_W-1:0] TICK_CNT,
   output logic              RUNNING
);

   localparam logic [DIV_W-1:0]  DIV_ZERO  = {DIV_W{1'b0}};
   localparam logic [DIV_W-1:0]  DIV_ONE   = {{(DIV_W-1){1'b0}}, 1'b1};
   localparam logic [TICK_W-1:0] TICK_ZERO = {TICK_W{1'b0}};
   localparam logic [TICK_W-1:0] TICK_ONE  = {{(TICK_W-1){1'b0}}, 1'b1};

   logic [2*SYNC_STAGES-1:0] mode_sync_q, mode_sync_d;
   clk_state_t               state_q, state_d;
   logic [DIV_W-1:0]         div_q, div_d;
   logic                     cpu_en_q, cpu_en_d;
   logic [TICK_W-1:0]        tick_q, tick_d;
   logic                     press_s;

   key_debounce #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEBOUNCE_W  (DEBOUNCE_W)
   ) u_step_key (
      .clk   (CLK),
      .rst_n (RESET_N),
      .key_n (STEP_KEY_N),
      .press (press_s)
   );

   // Enable decisions use the state before this edge, so a press or mode
   // change landing on the same edge is judged against the old mode.
   always_comb begin
      mode_sync_d = {mode_sync_q[2*SYNC_STAGES-3:0], MODE};
      state_d     = decode_mode(mode_sync_q[2*SYNC_STAGES-1 -: 2]);
      div_d       = div_q;
      cpu_en_d    = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (div_q >= DIV_N) begin
               div_d    = DIV_ZERO;
               cpu_en_d = 1'b1;
            end else begin
               div_d    = div_q + DIV_ONE;
               cpu_en_d = 1'b0;
            end
         end
         ST_FAST: cpu_en_d = 1'b1;
         ST_STEP: cpu_en_d = press_s;
         ST_HALT: cpu_en_d = 1'b0;
         default: cpu_en_d = 1'b0;
      endcase
      if ((state_q != ST_RUN) && (state_d == ST_RUN)) begin
         div_d = DIV_ZERO;
      end else begin
         div_d = div_d;
      end
      if (cpu_en_d) begin
         tick_d = tick_q + TICK_ONE;
      end else begin
         tick_d = tick_q;
      end
   end

   // Controller registers; reset parks the core in HALT with the enable low.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         mode_sync_q <= {(2*SYNC_STAGES){1'b0}};
         state_q     <= ST_HALT;
         div_q       <= DIV_ZERO;
         cpu_en_q    <= 1'b0;
         tick_q      <= TICK_ZERO;
      end else begin
         mode_sync_q <= mode_sync_d;
         state_q     <= state_d;
         div_q       <= div_d;
         cpu_en_q    <= cpu_en_d;
         tick_q      <= tick_d;
      end
   end

   assign CPU_EN   = cpu_en_q;
   assign TICK_CNT = tick_q;
   assign RUNNING  = (state_q == ST_RUN) || (state_q == ST_FAST);

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Directed bench for cpu_clk_ctrl with an abstract per-edge reference model.
module tb_cpu_clk_ctrl;

   localparam int DIV_W       = 8;
   localparam int DEBOUNCE_W  = 4;
   localparam int SYNC_STAGES = 2;
   localparam int TICK_W      = 4;
   localparam int STABLE_LEN  = 1 << DEBOUNCE_W;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [1:0]        mode;
   logic [DIV_W-1:0]  div_n;
   logic              key_n;
   logic              cpu_en;
   logic [TICK_W-1:0] tick_cnt;
   logic              running;

   int tests  = 0;
   int failed = 0;
   int pulse_cnt = 0;
   logic chk_on = 1'b0;

   cpu_clk_ctrl #(
      .DIV_W       (DIV_W),
      .DEBOUNCE_W  (DEBOUNCE_W),
      .SYNC_STAGES (SYNC_STAGES),
      .TICK_W      (TICK_W)
   ) dut (
      .CLK        (clk),
      .RESET_N    (rst_n),
      .MODE       (mode),
      .DIV_N      (div_n),
      .STEP_KEY_N (key_n),
      .CPU_EN     (cpu_en),
      .TICK_CNT   (tick_cnt),
      .RUNNING    (running)
   );

   always #5 clk = ~clk;

   // Reference model: inputs reach the core SYNC_STAGES edges late (delay
   // queues); a key level is accepted after STABLE_LEN disagreeing samples.
   logic [1:0]        m_mode_q[$];
   logic              m_key_q[$];
   logic [1:0]        m_state;
   logic              m_en;
   logic              m_press;
   logic              m_level;
   logic [TICK_W-1:0] m_tick;
   int                m_gap;
   int                m_stable;

   task automatic model_reset();
      m_mode_q.delete();
      m_key_q.delete();
      for (int i = 0; i < SYNC_STAGES; i++) begin
         m_mode_q.push_back(2'b00);
         m_key_q.push_back(1'b1);
      end
      m_state  = 2'b00;
      m_en     = 1'b0;
      m_press  = 1'b0;
      m_level  = 1'b1;
      m_tick   = '0;
      m_gap    = 0;
      m_stable = 0;
   endtask

   task automatic model_step();
      logic [1:0] new_state;
      logic       s;
      logic       new_press;
      m_mode_q.push_back(mode);
      new_state = m_mode_q.pop_front();
      case (m_state)
         2'b01: begin
            if (m_gap >= int'(div_n)) begin
               m_en  = 1'b1;
               m_gap = 0;
            end else begin
               m_en  = 1'b0;
               m_gap = m_gap + 1;
            end
         end
         2'b11:   m_en = 1'b1;
         2'b10:   m_en = m_press;
         default: m_en = 1'b0;
      endcase
      if (m_state != 2'b01 && new_state == 2'b01) m_gap = 0;
      if (m_en) m_tick = m_tick + 1'b1;
      m_key_q.push_back(key_n);
      s = m_key_q.pop_front();
      new_press = 1'b0;
      if (s == m_level) begin
         m_stable = 0;
      end else begin
         m_stable = m_stable + 1;
         if (m_stable == STABLE_LEN) begin
            m_level   = s;
            m_stable  = 0;
            new_press = (s == 1'b0);
         end
      end
      m_press = new_press;
      m_state = new_state;
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) model_reset();
      else        model_step();
   end

   // Every-cycle comparison of the DUT against the model.
   always @(negedge clk) begin
      if (chk_on) begin
         logic exp_run;
         exp_run = (m_state == 2'b01) || (m_state == 2'b11);
         tests++;
         if (cpu_en !== m_en || tick_cnt !== m_tick || running !== exp_run) begin
            failed++;
            $display("FAIL model t=%0t: CPU_EN/TICK_CNT/RUNNING got %b/%0d/%b, expected %b/%0d/%b",
                     $time, cpu_en, tick_cnt, running, m_en, m_tick, exp_run);
         end
      end
   end

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         failed++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic wait_edges(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic apply_reset(input logic [DIV_W-1:0] dn);
      @(negedge clk);
      #2 rst_n = 1'b0;
      mode  = 2'b00;
      key_n = 1'b1;
      div_n = dn;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic hold_key(input logic lvl, input int cycles);
      key_n = lvl;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (cpu_en) pulse_cnt++;
      end
   endtask

   initial begin
      rst_n = 1'b0;
      mode  = 2'b00;
      div_n = '0;
      key_n = 1'b1;
      model_reset();
      repeat (2) @(negedge clk);
      rst_n  = 1'b1;
      chk_on = 1'b1;

      // Reset values
      apply_reset(8'd0);
      check("reset CPU_EN", cpu_en, 0);
      check("reset TICK_CNT", tick_cnt, 0);
      check("reset RUNNING", running, 0);

      // Divided run, DIV_N=3: pulses at edges 7, 11, ... ; 16th at edge 67 wraps
      apply_reset(8'd3);
      mode = 2'b01;
      wait_edges(2);
      check("run RUNNING before sync", running, 0);
      wait_edges(1);
      check("run RUNNING after entry", running, 1);
      wait_edges(3);
      check("run no early pulse", cpu_en, 0);
      wait_edges(1);
      check("run first pulse", cpu_en, 1);
      check("run first tick", tick_cnt, 1);
      wait_edges(1);
      check("run pulse width", cpu_en, 0);
      wait_edges(59);
      check("run 16th pulse", cpu_en, 1);
      check("run tick wrap", tick_cnt, 0);

      // DIV_N=0: continuous enable from the second RUN edge
      apply_reset(8'd0);
      mode = 2'b01;
      wait_edges(3);
      check("div0 entry edge", cpu_en, 0);
      wait_edges(1);
      check("div0 first", cpu_en, 1);
      wait_edges(4);
      check("div0 continuous", cpu_en, 1);
      check("div0 tick", tick_cnt, 5);

      // FAST then HALT
      apply_reset(8'd3);
      mode = 2'b11;
      wait_edges(4);
      check("fast first", cpu_en, 1);
      check("fast first tick", tick_cnt, 1);
      wait_edges(9);
      check("fast tick 10", tick_cnt, 10);
      mode = 2'b00;
      wait_edges(4);
      check("halt enable low", cpu_en, 0);
      check("halt tick", tick_cnt, 13);
      wait_edges(5);
      check("halt tick frozen", tick_cnt, 13);
      check("halt RUNNING", running, 0);

      // Step with bounce
      apply_reset(8'd3);
      mode = 2'b10;
      wait_edges(5);
      pulse_cnt = 0;
      repeat (5) begin
         hold_key(1'b0, 3);
         hold_key(1'b1, 3);
      end
      hold_key(1'b0, 40);
      check("step single pulse", pulse_cnt, 1);
      check("step tick", tick_cnt, 1);
      pulse_cnt = 0;
      hold_key(1'b1, 40);
      check("step release silent", pulse_cnt, 0);
      check("step tick after release", tick_cnt, 1);

      // Press outside STEP is discarded
      apply_reset(8'd3);
      pulse_cnt = 0;
      hold_key(1'b0, 40);
      hold_key(1'b1, 40);
      check("halt press pulses", pulse_cnt, 0);
      check("halt press tick", tick_cnt, 0);

      // DIV_N shrink with divider at 7
      apply_reset(8'd10);
      mode = 2'b01;
      wait_edges(10);
      check("shrink before", cpu_en, 0);
      div_n = 8'd2;
      wait_edges(1);
      check("shrink immediate", cpu_en, 1);
      check("shrink tick", tick_cnt, 1);
      wait_edges(2);
      check("shrink gap", cpu_en, 0);
      wait_edges(1);
      check("shrink period 3", cpu_en, 1);
      check("shrink tick 2", tick_cnt, 2);

      // Asynchronous reset mid-run
      apply_reset(8'd3);
      mode = 2'b11;
      wait_edges(10);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async reset CPU_EN", cpu_en, 0);
      check("async reset TICK_CNT", tick_cnt, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      wait_edges(3);
      check("post reset hold", cpu_en, 0);
      check("post reset tick", tick_cnt, 0);
      check("post reset RUNNING", running, 1);
      wait_edges(1);
      check("post reset first", cpu_en, 1);

      wait_edges(2);
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
